// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

  // Sequencer states; the encoding is visible on state_o for debug.
  typedef enum logic [2:0] {
    StHold     = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFault    = 3'd4
  } pll_state_e;

  localparam int unsigned LOCK_LOSS_W = 8;

endpackage

// File: rtl/sync2.sv
// Generic 1-bit two-flop synchronizer with asynchronous active-low reset.
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops to resolve metastability on the async input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the PLL in reset, waits for a stable lock, then releases the system reset.
// Retries a bounded number of times before parking in FAULT.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                   refclk,
  input  logic                   rst_n,
  input  logic                   pll_locked,
  input  logic                   soft_rst,
  output logic                   pll_rst,
  output logic                   sys_rst_n,
  output logic                   fault,
  output logic [2:0]             state_o,
  output logic [LOCK_LOSS_W-1:0] lock_loss_cnt
);

  localparam int unsigned MaxHs  = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ?
                                   RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MaxCyc = (MaxHs > LOCK_TIMEOUT_CYCLES) ? MaxHs : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;
  localparam int unsigned RetW   = $clog2(MAX_RETRIES + 1);

  localparam logic [CntW-1:0] HoldLast    = CntW'(RST_HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RetW-1:0] RetMax      = RetW'(MAX_RETRIES);

  pll_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [RetW-1:0]       retries_q, retries_d;
  logic [RetW-1:0]       retries_inc;
  logic [LOCK_LOSS_W-1:0] llc_q, llc_d;
  logic                  pll_rst_q, sys_rst_n_q, fault_q;
  logic                  locked_s;

  sync2 u_sync_locked (
    .clk_i  (refclk),
    .rst_ni (rst_n),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );

  assign retries_inc = retries_q + RetW'(1);

  // Next-state, counter, retry and lock-loss bookkeeping.
  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    llc_d     = llc_q;
    // cnt is only meaningful in the timed states; park it elsewhere.
    cnt_d     = (state_q == StRun || state_q == StFault) ? cnt_q : cnt_q + CntW'(1);

    unique case (state_q)
      StHold: begin
        if (cnt_q == HoldLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (locked_s) begin
          state_d = StStable;
        end else if (cnt_q == TimeoutLast) begin
          retries_d = retries_inc;
          state_d   = (retries_inc == RetMax) ? StFault : StHold;
        end
      end
      StStable: begin
        // A dropout restarts the window without consuming a retry.
        if (!locked_s) begin
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        retries_d = '0;
        if (!locked_s) begin
          if (llc_q != '1) llc_d = llc_q + LOCK_LOSS_W'(1);
          state_d = StHold;
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StHold;
      end
    endcase

    // soft_rst overrides the transition but a coincident lock loss stays counted.
    if (soft_rst) begin
      state_d   = StHold;
      retries_d = '0;
    end

    if (soft_rst || state_d != state_q) cnt_d = '0;
  end

  // State register with outputs decoded from the next state so they change with it.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHold;
      cnt_q       <= '0;
      retries_q   <= '0;
      llc_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      llc_q       <= llc_d;
      pll_rst_q   <= (state_d == StHold) || (state_d == StFault);
      sys_rst_n_q <= (state_d == StRun);
      fault_q     <= (state_d == StFault);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign fault         = fault_q;
  assign state_o       = state_q;
  assign lock_loss_cnt = llc_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short hold/stable/timeout windows.
module tb_pll_reset_sequencer;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_rst;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       fault;
  logic [2:0] state_o;
  logic [7:0] lock_loss_cnt;

  int errors;
  int checks;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES     (16),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (100),
    .MAX_RETRIES         (3)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .soft_rst      (soft_rst),
    .pll_rst       (pll_rst),
    .sys_rst_n     (sys_rst_n),
    .fault         (fault),
    .state_o       (state_o),
    .lock_loss_cnt (lock_loss_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Advance until sys_rst_n equals val; n = limit+1 means the bound expired.
  task automatic wait_sys(input logic val, input int limit, output int n);
    n = 0;
    while (sys_rst_n !== val && n <= limit) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int limit, output int n);
    n = 0;
    while (state_o !== st && n <= limit) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b0; soft_rst = 1'b0;
    repeat (3) tick();
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst got=%b want=1", pll_rst); end
    checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL reset_sys_rst_n got=%b want=0", sys_rst_n); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b want=0", fault); end
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state_o); end
    checks++; if (lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL reset_llc got=%0d want=0", lock_loss_cnt); end
  endtask

  task automatic test_clean_start();
    rst_n = 1'b1;
    repeat (15) tick();
    checks++; if (pll_rst !== 1'b1 || state_o !== 3'd0) begin
      errors++; $display("FAIL hold_15 pll_rst=%b state=%0d want 1,0", pll_rst, state_o);
    end
    tick();
    checks++; if (pll_rst !== 1'b0 || state_o !== 3'd1) begin
      errors++; $display("FAIL hold_16 pll_rst=%b state=%0d want 0,1", pll_rst, state_o);
    end
    repeat (24) tick();
    pll_locked = 1'b1;
    tick();  // edge k samples lock
    tick();
    tick();  // k+2
    checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL stable_at_k2 got=%0d want=2", state_o); end
    repeat (7) tick();  // k+9
    checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL release_k9 got=%b want=0", sys_rst_n); end
    tick();  // k+10
    checks++; if (sys_rst_n !== 1'b1 || state_o !== 3'd3 || pll_rst !== 1'b0) begin
      errors++; $display("FAIL release_k10 sys=%b state=%0d pll_rst=%b want 1,3,0", sys_rst_n, state_o, pll_rst);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    bit waits_ok;
    for (int i = 0; i < 3; i++) begin
      pll_locked = 1'b0;
      tick();  // k
      tick();  // k+1
      checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("FAIL loss_k1 got=%b want=1", sys_rst_n); end
      tick();  // k+2
      checks++; if (sys_rst_n !== 1'b0 || pll_rst !== 1'b1 || state_o !== 3'd0) begin
        errors++; $display("FAIL loss_k2 sys=%b pll_rst=%b state=%0d want 0,1,0", sys_rst_n, pll_rst, state_o);
      end
      pll_locked = 1'b1;
      wait_sys(1'b1, 100, n);
      checks++; if (n > 100) begin errors++; $display("FAIL relock_timeout waited=%0d want<=100", n); end
      checks++; if (lock_loss_cnt !== 8'(i + 1)) begin
        errors++; $display("FAIL loss_count got=%0d want=%0d", lock_loss_cnt, i + 1);
      end
    end
    // soft_rst coinciding with the lock loss still counts it.
    pll_locked = 1'b0;
    tick();
    tick();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    checks++; if (lock_loss_cnt !== 8'd4 || state_o !== 3'd0) begin
      errors++; $display("FAIL soft_loss llc=%0d state=%0d want 4,0", lock_loss_cnt, state_o);
    end
    pll_locked = 1'b1;
    wait_sys(1'b1, 100, n);
    waits_ok = (n <= 100);
    for (int i = 5; i <= 300; i++) begin
      pll_locked = 1'b0;
      wait_sys(1'b0, 10, n);
      if (n > 10) waits_ok = 1'b0;
      pll_locked = 1'b1;
      wait_sys(1'b1, 100, n);
      if (n > 100) waits_ok = 1'b0;
      if (i == 255) begin
        checks++; if (lock_loss_cnt !== 8'd255) begin
          errors++; $display("FAIL llc_255 got=%0d want=255", lock_loss_cnt);
        end
      end
    end
    checks++; if (!waits_ok) begin errors++; $display("FAIL sat_loop_waits got=0 want=1"); end
    checks++; if (lock_loss_cnt !== 8'd255) begin errors++; $display("FAIL llc_sat got=%0d want=255", lock_loss_cnt); end
  endtask

  task automatic test_stable_glitch();
    int n;
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    checks++; if (state_o !== 3'd0 || sys_rst_n !== 1'b0 || lock_loss_cnt !== 8'd255) begin
      errors++; $display("FAIL soft_in_run state=%0d sys=%b llc=%0d want 0,0,255", state_o, sys_rst_n, lock_loss_cnt);
    end
    wait_state(3'd2, 40, n);
    checks++; if (n !== 17) begin errors++; $display("FAIL reach_stable got=%0d want=17", n); end
    repeat (5) tick();
    pll_locked = 1'b0;
    tick();  // j
    pll_locked = 1'b1;
    tick();  // j+1
    checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL glitch_j1 got=%0d want=2", state_o); end
    tick();  // j+2
    checks++; if (state_o !== 3'd1 || sys_rst_n !== 1'b0 || dut.retries_q !== 2'd0) begin
      errors++; $display("FAIL glitch_j2 state=%0d sys=%b retries=%0d want 1,0,0", state_o, sys_rst_n, dut.retries_q);
    end
    tick();  // j+3
    checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL glitch_j3 got=%0d want=2", state_o); end
    repeat (7) tick();  // j+10
    checks++; if (state_o !== 3'd2 || sys_rst_n !== 1'b0) begin
      errors++; $display("FAIL glitch_j10 state=%0d sys=%b want 2,0", state_o, sys_rst_n);
    end
    tick();  // j+11
    checks++; if (state_o !== 3'd3 || sys_rst_n !== 1'b1) begin
      errors++; $display("FAIL glitch_j11 state=%0d sys=%b want 3,1", state_o, sys_rst_n);
    end
  endtask

  task automatic test_timeout_fault();
    int n;
    int holds;
    pll_locked = 1'b0;
    soft_rst = 1'b1;
    tick();  // k
    soft_rst = 1'b0;
    holds = (state_o === 3'd0) ? 1 : 0;
    n = 0;
    while (fault !== 1'b1 && n < 1000) begin
      tick();
      n++;
      if (state_o === 3'd0) holds++;
    end
    checks++; if (n !== 348) begin errors++; $display("FAIL fault_latency got=%0d want=348", n); end
    checks++; if (holds !== 48) begin errors++; $display("FAIL hold_cycles got=%0d want=48", holds); end
    checks++; if (state_o !== 3'd4 || pll_rst !== 1'b1 || sys_rst_n !== 1'b0) begin
      errors++; $display("FAIL fault_outs state=%0d pll_rst=%b sys=%b want 4,1,0", state_o, pll_rst, sys_rst_n);
    end
    repeat (20) tick();
    checks++; if (fault !== 1'b1 || pll_rst !== 1'b1 || state_o !== 3'd4) begin
      errors++; $display("FAIL fault_sticky fault=%b pll_rst=%b state=%0d want 1,1,4", fault, pll_rst, state_o);
    end
  endtask

  task automatic test_recovery();
    int n;
    soft_rst = 1'b1;
    pll_locked = 1'b1;
    tick();
    soft_rst = 1'b0;
    checks++; if (state_o !== 3'd0 || fault !== 1'b0 || pll_rst !== 1'b1 || dut.retries_q !== 2'd0) begin
      errors++; $display("FAIL recover state=%0d fault=%b pll_rst=%b retries=%0d want 0,0,1,0",
                         state_o, fault, pll_rst, dut.retries_q);
    end
    wait_sys(1'b1, 100, n);
    checks++; if (n !== 25 || state_o !== 3'd3) begin
      errors++; $display("FAIL recover_run cycles=%0d state=%0d want 25,3", n, state_o);
    end
  endtask

  task automatic test_soft_timeout();
    pll_locked = 1'b0;
    soft_rst = 1'b1;
    tick();  // k
    soft_rst = 1'b0;
    repeat (231) tick();  // k+231
    checks++; if (state_o !== 3'd1 || dut.retries_q !== 2'd1) begin
      errors++; $display("FAIL pre_timeout state=%0d retries=%0d want 1,1", state_o, dut.retries_q);
    end
    soft_rst = 1'b1;
    tick();  // k+232, timeout edge
    soft_rst = 1'b0;
    checks++; if (state_o !== 3'd0 || dut.retries_q !== 2'd0 || pll_rst !== 1'b1) begin
      errors++; $display("FAIL soft_timeout state=%0d retries=%0d pll_rst=%b want 0,0,1",
                         state_o, dut.retries_q, pll_rst);
    end
  endtask

  task automatic test_async_reset();
    int n;
    pll_locked = 1'b1;
    wait_state(3'd2, 60, n);
    checks++; if (n > 60) begin errors++; $display("FAIL reach_stable2 waited=%0d want<=60", n); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || fault !== 1'b0 ||
                  state_o !== 3'd0 || lock_loss_cnt !== 8'd0) begin
      errors++; $display("FAIL async_reset pll_rst=%b sys=%b fault=%b state=%0d llc=%0d want 1,0,0,0,0",
                         pll_rst, sys_rst_n, fault, state_o, lock_loss_cnt);
    end
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_clean_start();
    test_lock_loss();
    test_stable_glitch();
    test_timeout_fault();
    test_recovery();
    test_soft_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
